dma_mc: RTL and testbench
=========================

# dma_mc

Multi-channel successor to the single-channel cartridge/VRAM DMA engine: up to NCH independent channels share one 8-bit memory port and move bursts of LEN_UNIT-byte blocks between two address spaces. Each channel has its own source, destination, length and mode and is armed by a rising edge of its start bit. A round-robin arbiter chooses among pending channels. Sticky per-channel done flags drive the interrupt controller. The block sits between the register file and the system bus mux, and the CPU is halted through `busy`.

## Interface
- `NCH`, 2: number of channels, 1..4.
- `AW`, 13: transfer address width; addresses wrap modulo 2^AW.
- `LW`, 8: length register width, in units.
- `LEN_UNIT`, 16: bytes per length unit; power of two.
- `clk`  in  1: system clock (4x CPU).
- `reset_n`  in  1: reset, asynchronous, active-low.
- `rdy`  in  1: bus grant; when low the engine freezes in place.
- `start`  in  NCH: per-channel arm bit; a rising edge requests a transfer.
- `src_addr`  in  NCH*AW: per-channel source address, channel i at bits [i*AW +: AW].
- `dst_addr`  in  NCH*AW: per-channel destination address, packed the same way.
- `length`  in  NCH*LW: per-channel length in units.
- `dir`  in  NCH: 1 = src→dst, 0 = dst→src (swap roles); drives `sel`.
- `fill`  in  NCH: 1 = read address held constant (fill/port mode).
- `irq_ack`  in  NCH: clears the matching `done` bits.
- `addr`  out  AW: bus address.
- `din`  in  8: read data, valid the cycle after the read address.
- `dout`  out  8: write data.
- `write`  out  1: write strobe.
- `sel`  out  1: `dir` of the active channel; 0 when idle.
- `busy`  out  NCH: channel pending or active.
- `done`  out  NCH: sticky completion flags.

## Operation
- Start edge detect: a registered copy of `start` runs every cycle, independent of `rdy`. A rising edge sets `pending[i]`. An edge on a channel already busy is ignored.
- State machine states: IDLE, LOAD, READ, WRITE. All state advances are gated by `rdy`.
- IDLE → LOAD when any bit of `pending` is set. The arbiter grants the lowest-index pending channel at or after `last_grant+1`, wrapping. Grant clears that channel's `pending` bit and latches it as `cur`.
- LOAD does the following:
  - Samples `cur`'s registers.
  - Sets `rd_ptr` = dir ? src : dst and `wr_ptr` = dir ? dst : src.
  - Sets `count` = length*LEN_UNIT, width LW+log2(LEN_UNIT).
  - If `count`==0, goes to IDLE and sets `done[cur]`. Otherwise goes to READ.
- READ drives `addr`=`rd_ptr`, then goes to WRITE.
- WRITE does the following:
  - Drives `addr`=`wr_ptr`, `write`=1 and `dout`=`din`.
  - Increments `wr_ptr`. Increments `rd_ptr` unless `fill[cur]`.
  - Decrements `count`.
  - If the decremented value is 0, goes to IDLE and sets `done[cur]`. Otherwise goes to READ.
- No preemption: a granted channel runs to completion.
- `done[i]`: set on completion, cleared by `irq_ack[i]`. If set and clear happen in the same cycle, set wins.
- `busy[i]` = `pending[i]` | (state≠IDLE & `cur`==i).
- Input registers of the active channel changing mid-transfer have no effect until its next LOAD.
- Reset values (asynchronous, applied immediately on `reset_n` low): state=IDLE; `pending`, `done`, `busy`, `write`, `sel`, `addr` and `dout` = 0; `last_grant` = NCH-1. Reset mid-transfer abandons the transfer and sets no `done` bit.

## Timing
- Start at edge k, given `rdy`=1 and IDLE:
  - `pending`/`busy` high after edge k.
  - LOAD after k+1.
  - First READ after k+2.
  - Each byte takes 2 cycles, READ then WRITE.
- N bytes: `busy` and `done` change together after edge k+2+2N.
- `rdy` low: state, pointers, count and arbitration hold. `addr`, `dout` and `write` are forced to 0. Start edges are still captured. `done` still clears on ack.
- Output timing:
  - `addr` and `write` are decoded combinationally from state and pointers.
  - `dout` is combinational from `din` in WRITE, 0 otherwise.
  - `sel` is combinational from the latched `dir` of `cur`.

## Structure
- Package `dma_pkg` contains:
  - the state enum `dma_state_t` (IDLE, LOAD, READ, WRITE);
  - default parameter constants;
  - the count-width function `cnt_w(LW, LEN_UNIT)`.
- Sub-module `rr_arbiter`, parametrised by NCH:
  - inputs: request vector, `last_grant`, enable;
  - outputs: one-hot grant and encoded index;
  - purely combinational. The `last_grant` register lives in `dma_mc`.

## Test plan
- Ch0, dir=1, src=0x0100, dst=0x1F00, length=1:
  - 16 reads at 0x0100..0x010F, each followed by a write at 0x1F00..0x1F0F;
  - `done[0]` is set 34 cycles after the start edge.
- dst wrap: dst=0x1FF8, length=1. Writes go 0x1FF8..0x1FFF, then 0x0000..0x0007.
- Length 0:
  - no `write` strobe;
  - `done` is set 2 cycles after the start edge;
  - `busy` is high for 2 cycles.
- Ch0 and ch1 started in the same cycle, then ch0 restarted while ch1 runs:
  - order is ch0, ch1, ch0 (round-robin);
  - a start edge on ch1 while ch1 is busy is ignored.
- `rdy` low for 5 cycles mid-WRITE:
  - outputs are 0 and the pointers do not move;
  - the transfer resumes at the same byte;
  - total bytes = 16;
  - fill=1 keeps the read address constant.
- `reset_n` low mid-transfer: all outputs 0 at once and no `done`. Separately, `irq_ack` asserted in the same cycle as completion leaves `done`=1.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared types and constants for the multi-channel DMA engine.
package dma_pkg;

  // Engine sequencing: arbitrate, load channel context, then alternate read/write per byte.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READ  = 2'd2,
    WRITE = 2'd3
  } dma_state_t;

  localparam int DEF_NCH      = 2;
  localparam int DEF_AW       = 13;
  localparam int DEF_LW       = 8;
  localparam int DEF_LEN_UNIT = 16;

  // Byte counter width: a full length in units expanded to bytes.
  function automatic int cnt_w(input int lw, input int len_unit);
    return lw + $clog2(len_unit);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: lowest-index requester at or after last_grant+1, wrapping.
module rr_arbiter #(
  parameter int NCH = 2,
  parameter int IW  = 1
) (
  input  logic [NCH-1:0] req,
  input  logic [IW-1:0]  last_grant,
  input  logic           en,
  output logic [NCH-1:0] gnt,
  output logic [IW-1:0]  gnt_idx
);

  logic          found;
  logic [IW-1:0] idx;

  // Scan channels in rotated order starting just past the previous winner.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 1; k <= NCH; k++) begin
      idx = IW'((int'(last_grant) + k) % NCH);
      if (en && !found && req[idx]) begin
        found      = 1'b1;
        gnt[idx]   = 1'b1;
        gnt_idx    = idx;
      end
    end
  end

endmodule

// File: rtl/dma_mc.sv
// Multi-channel block-copy DMA: NCH channels share one 8-bit bus port, served round-robin.
module dma_mc
  import dma_pkg::*;
#(
  parameter int NCH      = DEF_NCH,
  parameter int AW       = DEF_AW,
  parameter int LW       = DEF_LW,
  parameter int LEN_UNIT = DEF_LEN_UNIT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rdy,
  input  logic [NCH-1:0]    start,
  input  logic [NCH*AW-1:0] src_addr,
  input  logic [NCH*AW-1:0] dst_addr,
  input  logic [NCH*LW-1:0] length,
  input  logic [NCH-1:0]    dir,
  input  logic [NCH-1:0]    fill,
  input  logic [NCH-1:0]    irq_ack,
  output logic [AW-1:0]     addr,
  input  logic [7:0]        din,
  output logic [7:0]        dout,
  output logic              write,
  output logic              sel,
  output logic [NCH-1:0]    busy,
  output logic [NCH-1:0]    done
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW = cnt_w(LW, LEN_UNIT);
  localparam int UB = $clog2(LEN_UNIT);

  // Per-channel views of the packed configuration buses.
  logic [AW-1:0] src_a [NCH];
  logic [AW-1:0] dst_a [NCH];
  logic [LW-1:0] len_a [NCH];

  dma_state_t    state_reg, state_next;
  logic [IW-1:0] cur_reg, cur_next;
  logic [IW-1:0] last_grant_reg, last_grant_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic          dir_reg, dir_next;
  logic          fill_reg, fill_next;
  logic [NCH-1:0] pending_reg, pending_next;
  logic [NCH-1:0] done_reg, done_next;
  logic [NCH-1:0] start_d_reg;
  logic [NCH-1:0] start_rise;
  logic [NCH-1:0] done_set;
  logic [NCH-1:0] gnt;
  logic [IW-1:0]  gnt_idx;
  logic           arb_en;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_chan
      assign src_a[gi] = src_addr[gi*AW +: AW];
      assign dst_a[gi] = dst_addr[gi*AW +: AW];
      assign len_a[gi] = length[gi*LW +: LW];
      // A channel is busy from arm until its last byte retires.
      assign busy[gi]  = pending_reg[gi] |
                         ((state_reg != IDLE) && (cur_reg == IW'(gi)));
    end
  endgenerate

  assign start_rise = start & ~start_d_reg;
  assign arb_en     = rdy && (state_reg == IDLE);
  assign done       = done_reg;

  rr_arbiter #(
    .NCH (NCH),
    .IW  (IW)
  ) u_arb (
    .req        (pending_reg),
    .last_grant (last_grant_reg),
    .en         (arb_en),
    .gnt        (gnt),
    .gnt_idx    (gnt_idx)
  );

  // Next-state logic: edge capture always runs; sequencing only advances with rdy.
  always_comb begin
    state_next      = state_reg;
    cur_next        = cur_reg;
    last_grant_next = last_grant_reg;
    rd_ptr_next     = rd_ptr_reg;
    wr_ptr_next     = wr_ptr_reg;
    count_next      = count_reg;
    dir_next        = dir_reg;
    fill_next       = fill_reg;
    done_set        = '0;
    // Re-arming a busy channel is ignored so a running transfer is never queued twice.
    pending_next    = pending_reg | (start_rise & ~busy);

    if (rdy) begin
      case (state_reg)
        IDLE: begin
          if (|pending_reg) begin
            state_next      = LOAD;
            cur_next        = gnt_idx;
            last_grant_next = gnt_idx;
            pending_next    = pending_next & ~gnt;
          end
        end
        LOAD: begin
          dir_next    = dir[cur_reg];
          fill_next   = fill[cur_reg];
          rd_ptr_next = dir[cur_reg] ? src_a[cur_reg] : dst_a[cur_reg];
          wr_ptr_next = dir[cur_reg] ? dst_a[cur_reg] : src_a[cur_reg];
          count_next  = CW'(len_a[cur_reg]) << UB;
          if (len_a[cur_reg] == '0) begin
            state_next        = IDLE;
            done_set[cur_reg] = 1'b1;
          end else begin
            state_next = READ;
          end
        end
        READ: begin
          state_next = WRITE;
        end
        WRITE: begin
          wr_ptr_next = wr_ptr_reg + AW'(1);
          rd_ptr_next = rd_ptr_reg + AW'(!fill_reg);
          count_next  = count_reg - CW'(1);
          if (count_reg == CW'(1)) begin
            state_next        = IDLE;
            done_set[cur_reg] = 1'b1;
          end else begin
            state_next = READ;
          end
        end
      endcase
    end

    // A completion in the same cycle as an ack must not be lost.
    done_next = (done_reg & ~irq_ack) | done_set;
  end

  // State and context registers; reset abandons any transfer without flagging done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      cur_reg        <= '0;
      last_grant_reg <= IW'(NCH - 1);
      rd_ptr_reg     <= '0;
      wr_ptr_reg     <= '0;
      count_reg      <= '0;
      dir_reg        <= 1'b0;
      fill_reg       <= 1'b0;
      pending_reg    <= '0;
      done_reg       <= '0;
      start_d_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      cur_reg        <= cur_next;
      last_grant_reg <= last_grant_next;
      rd_ptr_reg     <= rd_ptr_next;
      wr_ptr_reg     <= wr_ptr_next;
      count_reg      <= count_next;
      dir_reg        <= dir_next;
      fill_reg       <= fill_next;
      pending_reg    <= pending_next;
      done_reg       <= done_next;
      start_d_reg    <= start;
    end
  end

  // Bus outputs decoded from state; everything drops to 0 while the bus is not granted.
  always_comb begin
    addr  = '0;
    write = 1'b0;
    dout  = '0;
    if (rdy) begin
      if (state_reg == READ) begin
        addr = rd_ptr_reg;
      end else if (state_reg == WRITE) begin
        addr  = wr_ptr_reg;
        write = 1'b1;
        dout  = din;
      end
    end
  end

  // Bus-mux select follows the active channel's direction; LOAD shows the live bit being sampled.
  always_comb begin
    sel = 1'b0;
    if (state_reg == LOAD) begin
      sel = dir[cur_reg];
    end else if (state_reg != IDLE) begin
      sel = dir_reg;
    end
  end

endmodule

// File: tb/tb_dma_mc.sv
// Randomized and directed bench for dma_mc with a transfer-level reference model.
module tb_dma_mc;

  localparam int NCH = 2;
  localparam int AW  = 13;
  localparam int LW  = 8;
  localparam int LU  = 16;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              rdy;
  logic [NCH-1:0]    start;
  logic [NCH*AW-1:0] src_addr;
  logic [NCH*AW-1:0] dst_addr;
  logic [NCH*LW-1:0] length;
  logic [NCH-1:0]    dir;
  logic [NCH-1:0]    fill;
  logic [NCH-1:0]    irq_ack;
  logic [AW-1:0]     addr;
  logic [7:0]        din;
  logic [7:0]        dout;
  logic              write;
  logic              sel;
  logic [NCH-1:0]    busy;
  logic [NCH-1:0]    done;

  dma_mc #(.NCH(NCH), .AW(AW), .LW(LW), .LEN_UNIT(LU)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .rdy      (rdy),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .length   (length),
    .dir      (dir),
    .fill     (fill),
    .irq_ack  (irq_ack),
    .addr     (addr),
    .din      (din),
    .dout     (dout),
    .write    (write),
    .sel      (sel),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [7:0]    d;
    logic          s;
  } wr_t;

  wr_t exp_q[$];
  wr_t obs_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  logic [AW-1:0] bus_addr  = '0;
  logic          bus_valid = 1'b0;

  // Memory contents are a fixed function of address, so written data identifies the byte read.
  function automatic logic [7:0] mem_byte(input logic [AW-1:0] a);
    return a[7:0] ^ {a[12:8], 3'b101} ^ 8'h3C;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: memory answers the previous granted read, then outputs are sampled.
  task automatic tick(input logic r);
    @(posedge clk);
    #1;
    rdy = r;
    if (bus_valid) din = mem_byte(bus_addr);
    #1;
    bus_addr  = addr;
    bus_valid = rdy && !write;
    if (write) obs_q.push_back('{addr, dout, sel});
  endtask

  // Reference: byte b reads rd_base(+b unless fill) and writes wr_base+b, modulo 2^AW.
  task automatic model_xfer(input logic [AW-1:0] s, input logic [AW-1:0] d,
                            input int len, input logic dr, input logic fl);
    logic [AW-1:0] rb, wb, ra, wa;
    rb = dr ? s : d;
    wb = dr ? d : s;
    for (int b = 0; b < len * LU; b++) begin
      ra = fl ? rb : AW'(int'(rb) + b);
      wa = AW'(int'(wb) + b);
      exp_q.push_back('{wa, mem_byte(ra), dr});
    end
  endtask

  task automatic compare_writes(input string tag);
    int n;
    check_eq({tag, "_nwrites"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check_eq({tag, "_waddr"}, obs_q[i].a, exp_q[i].a);
      check_eq({tag, "_wdata"}, obs_q[i].d, exp_q[i].d);
      check_eq({tag, "_sel"},   obs_q[i].s, exp_q[i].s);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic config_ch(input int ch, input logic [AW-1:0] s, input logic [AW-1:0] d,
                           input int len, input logic dr, input logic fl);
    src_addr[ch*AW +: AW] = s;
    dst_addr[ch*AW +: AW] = d;
    length[ch*LW +: LW]   = LW'(len);
    dir[ch]               = dr;
    fill[ch]              = fl;
  endtask

  // Single transfer from arm to done, optionally stalling the bus 5 cycles before write stall_at.
  task automatic run_xfer(input string tag, input int ch, input logic [AW-1:0] s,
                          input logic [AW-1:0] d, input int len, input logic dr,
                          input logic fl, input int stall_at);
    int cnt, bcnt, lat_exp, stall_left, phase, nbytes;
    logic r, first, stall_done, timed_out;
    config_ch(ch, s, d, len, dr, fl);
    obs_q.delete();
    exp_q.delete();
    model_xfer(s, d, len, dr, fl);
    nbytes  = len * LU;
    lat_exp = 2 + 2 * nbytes + ((stall_at > 0 && stall_at < nbytes) ? 5 : 0);
    cnt = 0; bcnt = 0; stall_left = 0; phase = 0;
    first = 1'b1; stall_done = 1'b0; timed_out = 1'b0;
    start[ch] = 1'b1;
    forever begin
      r = (stall_left > 0) ? 1'b0 : 1'b1;
      tick(r);
      if (first) begin
        check_eq({tag, "_busy_on_arm"}, busy[ch], 1'b1);
        start[ch] = 1'b0;
        first     = 1'b0;
      end
      if (!r) begin
        check_eq({tag, "_stall_outs"}, {addr, dout, write}, '0);
        stall_left--;
      end else if (phase == 1) begin
        phase      = 0;
        stall_left = 5;
        stall_done = 1'b1;
      end else if (stall_at > 0 && !stall_done && write && obs_q.size() == stall_at) begin
        phase = 1;
      end
      if (done[ch]) break;
      cnt++;
      if (busy[ch]) bcnt++;
      if (cnt > 1000) begin
        timed_out = 1'b1;
        break;
      end
    end
    check_eq({tag, "_timeout"}, timed_out, 1'b0);
    check_eq({tag, "_latency"}, cnt, lat_exp);
    check_eq({tag, "_busy_cycles"}, bcnt, lat_exp);
    check_eq({tag, "_busy_at_done"}, busy[ch], 1'b0);
    $display("xfer %s ch%0d src=%h dst=%h len=%0d dir=%0d fill=%0d writes=%0d cycles=%0d",
             tag, ch, s, d, len, dr, fl, obs_q.size(), cnt);
    compare_writes(tag);
    irq_ack[ch] = 1'b1;
    tick(1'b1);
    irq_ack[ch] = 1'b0;
    check_eq({tag, "_done_cleared"}, done[ch], 1'b0);
  endtask

  initial begin
    int t;
    logic to;
    reset_n  = 1'b0;
    rdy      = 1'b1;
    start    = '0;
    src_addr = '0;
    dst_addr = '0;
    length   = '0;
    dir      = '0;
    fill     = '0;
    irq_ack  = '0;
    din      = '0;

    #12;
    check_eq("rst_addr",  addr,  '0);
    check_eq("rst_write", write, 1'b0);
    check_eq("rst_dout",  dout,  '0);
    check_eq("rst_sel",   sel,   1'b0);
    check_eq("rst_busy",  busy,  '0);
    check_eq("rst_done",  done,  '0);
    reset_n = 1'b1;
    tick(1'b1);
    tick(1'b1);

    // Basic copy, then a destination that wraps the address space.
    run_xfer("basic", 0, 13'h0100, 13'h1F00, 1, 1'b1, 1'b0, -1);
    run_xfer("dwrap", 1, 13'h0040, 13'h1FF8, 1, 1'b1, 1'b0, -1);

    // Both channels armed together, ch0 re-armed while ch1 runs, ch1 re-armed while busy.
    config_ch(0, 13'h0200, 13'h0A00, 1, 1'b1, 1'b0);
    config_ch(1, 13'h0300, 13'h0B40, 1, 1'b0, 1'b0);
    obs_q.delete();
    exp_q.delete();
    model_xfer(13'h0200, 13'h0A00, 1, 1'b1, 1'b0);
    model_xfer(13'h0300, 13'h0B40, 1, 1'b0, 1'b0);
    model_xfer(13'h0200, 13'h0A00, 1, 1'b1, 1'b0);
    start = 2'b11;
    tick(1'b1);
    start = 2'b00;
    to = 1'b1;
    for (t = 0; t < 300; t++) begin
      tick(1'b1);
      if (done[0]) begin
        to = 1'b0;
        break;
      end
    end
    check_eq("rr_ch0_first_timeout", to, 1'b0);
    check_eq("rr_ch1_waiting", busy[1], 1'b1);
    irq_ack[0] = 1'b1;
    start      = 2'b11;
    tick(1'b1);
    irq_ack[0] = 1'b0;
    start      = 2'b00;
    to = 1'b1;
    for (t = 0; t < 400; t++) begin
      tick(1'b1);
      if (busy == '0) begin
        to = 1'b0;
        break;
      end
    end
    check_eq("rr_idle_timeout", to, 1'b0);
    for (int i = 0; i < 6; i++) tick(1'b1);
    check_eq("rr_stays_idle", busy, '0);
    check_eq("rr_done_both", done, 2'b11);
    $display("xfer rr order ch0,ch1,ch0 writes=%0d", obs_q.size());
    compare_writes("rr");
    irq_ack = 2'b11;
    tick(1'b1);
    irq_ack = 2'b00;

    // Zero-length transfer completes from LOAD without touching the bus.
    run_xfer("len0", 0, 13'h0500, 13'h0600, 0, 1'b1, 1'b0, -1);

    // Random transfers.
    for (int i = 0; i < 8; i++) begin
      run_xfer("rand", int'($urandom_range(0, NCH - 1)), AW'($urandom), AW'($urandom),
               int'($urandom_range(0, 2)), 1'($urandom), 1'($urandom), -1);
    end

    // Bus withdrawn for 5 cycles mid-WRITE in fill mode.
    run_xfer("stall", 1, 13'h0777, 13'h1200, 1, 1'b1, 1'b1, 5);
    run_xfer("stall_rev", 0, 13'h0ABC, 13'h1FFC, 1, 1'b0, 1'b0, 9);

    // Ack held across completion: the set must win, then the held ack clears it.
    config_ch(0, 13'h0010, 13'h0020, 0, 1'b1, 1'b0);
    irq_ack[0] = 1'b1;
    start[0]   = 1'b1;
    tick(1'b1);
    start[0]   = 1'b0;
    tick(1'b1);
    check_eq("ack_pre_done", done[0], 1'b0);
    tick(1'b1);
    check_eq("ack_set_wins", done[0], 1'b1);
    tick(1'b1);
    check_eq("ack_then_clear", done[0], 1'b0);
    irq_ack[0] = 1'b0;

    // Reset in the middle of a transfer.
    config_ch(0, 13'h0100, 13'h0900, 2, 1'b1, 1'b0);
    start[0] = 1'b1;
    tick(1'b1);
    start[0] = 1'b0;
    for (int i = 0; i < 12; i++) tick(1'b1);
    check_eq("mid_busy_before_rst", busy[0], 1'b1);
    #1;
    reset_n = 1'b0;
    #1;
    check_eq("mrst_addr",  addr,  '0);
    check_eq("mrst_write", write, 1'b0);
    check_eq("mrst_dout",  dout,  '0);
    check_eq("mrst_sel",   sel,   1'b0);
    check_eq("mrst_busy",  busy,  '0);
    check_eq("mrst_done",  done,  '0);
    tick(1'b1);
    tick(1'b1);
    reset_n = 1'b1;
    obs_q.delete();
    for (int i = 0; i < 5; i++) tick(1'b1);
    check_eq("post_rst_busy",   busy, '0);
    check_eq("post_rst_done",   done, '0);
    check_eq("post_rst_writes", obs_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
